// File: rtl/acc_adapter_sb.sv
// Offload adapter between a core request port and an accelerator queue.
// Picks a predecoder winner, builds operands, tracks pending destination
// registers in a scoreboard and limits in-flight writeback offloads.
module acc_adapter_sb #(
    parameter int DataWidth      = 32,
    parameter int NumPrd         = 8,
    parameter int FifoDepth      = 2,
    parameter int MaxOutstanding = 4,
    localparam int AddrWidth     = (NumPrd > 1) ? $clog2(NumPrd) : 1,
    localparam int CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   q_valid_i,
    output logic                   q_ready_o,
    input  logic [31:0]            q_instr_data_i,
    input  logic [3*DataWidth-1:0] q_rs_i,
    input  logic [2:0]             q_rs_valid_i,
    output logic                   k_accept_o,
    output logic                   k_writeback_o,
    output logic [31:0]            prd_instr_data_o,
    input  logic [NumPrd-1:0]      prd_accept_i,
    input  logic [3*NumPrd-1:0]    prd_use_rs_i,
    input  logic [NumPrd-1:0]      prd_writeback_i,
    input  logic [3*NumPrd-1:0]    prd_op_imm_i,
    input  logic [9*NumPrd-1:0]    prd_imm_sel_i,
    output logic                   acc_q_valid_o,
    input  logic                   acc_q_ready_i,
    output logic [AddrWidth-1:0]   acc_q_addr_o,
    output logic [31:0]            acc_q_data_op_o,
    output logic [3*DataWidth-1:0] acc_q_arg_o,
    output logic [4:0]             acc_q_id_o,
    input  logic                   acc_p_valid_i,
    output logic                   acc_p_ready_o,
    input  logic [DataWidth-1:0]   acc_p_data_i,
    input  logic [4:0]             acc_p_id_i,
    output logic                   p_valid_o,
    input  logic                   p_ready_i,
    output logic [DataWidth-1:0]   p_data_o,
    output logic [4:0]             p_id_o,
    output logic [CntWidth-1:0]    outstanding_o,
    output logic                   err_o
);

    localparam int PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int LvlWidth = $clog2(FifoDepth + 1);

    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic [31:0]            instr;
        logic [3*DataWidth-1:0] args;
        logic [4:0]             rd;
    } entry_t;

    // RISC-V immediate of the selected format, sign-extended to DataWidth
    function automatic logic [DataWidth-1:0] imm_ext(input logic [31:0] ins, input logic [2:0] sel);
        logic [31:0] imm;
        case (sel)
            3'd1:    imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3'd2:    imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd3:    imm = {ins[31:12], 12'b0};
            3'd4:    imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = {{20{ins[31]}}, ins[31:20]};
        endcase
        return DataWidth'($signed(imm));
    endfunction

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    logic                   win_found;
    logic [AddrWidth-1:0]   win_idx;
    logic                   win_wb;
    logic [2:0]             win_use_rs;
    logic [2:0]             win_op_imm;
    logic [8:0]             win_imm_sel;
    logic [3*DataWidth-1:0] args;
    logic [4:0]             rd;
    logic                   tracked, resp_hs, src_miss, fifo_full, out_full, sb_hazard;
    logic                   stall, push, pop, inc, dec;
    logic [31:0]            sb_q, sb_next;
    logic [CntWidth-1:0]    out_q;
    logic                   err_q;
    entry_t                 mem [FifoDepth];
    entry_t                 head;
    logic [PtrWidth-1:0]    wr_ptr, rd_ptr;
    logic [LvlWidth-1:0]    level;

    assign prd_instr_data_o = q_instr_data_i;
    assign k_accept_o       = |prd_accept_i;
    assign k_writeback_o    = win_wb;

    // Lowest-index accepting predecoder wins and supplies the decode attributes
    always_comb begin
        win_found   = 1'b0;
        win_idx     = '0;
        win_wb      = 1'b0;
        win_use_rs  = '0;
        win_op_imm  = '0;
        win_imm_sel = '0;
        for (int unsigned i = 0; i < NumPrd; i++) begin
            if (prd_accept_i[i] && !win_found) begin
                win_found   = 1'b1;
                win_idx     = AddrWidth'(i);
                win_wb      = prd_writeback_i[i];
                win_use_rs  = prd_use_rs_i[3*i +: 3];
                win_op_imm  = prd_op_imm_i[3*i +: 3];
                win_imm_sel = prd_imm_sel_i[9*i +: 9];
            end
        end
    end

    // Operand selection: register source or decoded immediate
    always_comb begin
        args = '0;
        for (int unsigned j = 0; j < 3; j++) begin
            args[j*DataWidth +: DataWidth] = win_op_imm[j]
                ? imm_ext(q_instr_data_i, win_imm_sel[3*j +: 3])
                : q_rs_i[j*DataWidth +: DataWidth];
        end
    end

    // Hazard and capacity checks; a response retiring rd this cycle unblocks it
    always_comb begin
        rd        = q_instr_data_i[11:7];
        tracked   = win_wb && (rd != 5'd0);
        resp_hs   = acc_p_valid_i && p_ready_i;
        src_miss  = |(win_use_rs & ~q_rs_valid_i);
        fifo_full = (level == LvlWidth'(FifoDepth));
        out_full  = (out_q == CntWidth'(MaxOutstanding));
        sb_hazard = tracked && sb_q[rd] && !(resp_hs && (acc_p_id_i == rd));
        stall     = k_accept_o && (src_miss || fifo_full || (win_wb && out_full) || sb_hazard);
        q_ready_o = !k_accept_o || !stall;
        push      = q_valid_i && k_accept_o && !stall;
        pop       = (level != '0) && acc_q_ready_i;
        inc       = push && win_wb;
        dec       = resp_hs && (out_q != '0);
    end

    // FIFO storage write; contents need no reset because level gates visibility
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: win_idx, instr: q_instr_data_i, args: args, rd: rd};
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // Scoreboard update: clear on response first, so a same-cycle set wins
    always_comb begin
        sb_next = sb_q;
        if (resp_hs && (acc_p_id_i != 5'd0)) sb_next[acc_p_id_i] = 1'b0;
        if (push && tracked)                 sb_next[rd]         = 1'b1;
    end

    // Scoreboard, outstanding counter and sticky protocol error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sb_q  <= '0;
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            sb_q <= sb_next;
            if (inc && !dec)      out_q <= out_q + 1'b1;
            else if (dec && !inc) out_q <= out_q - 1'b1;
            if (resp_hs && ((out_q == '0) || ((acc_p_id_i != 5'd0) && !sb_q[acc_p_id_i]))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign head            = mem[rd_ptr];
    assign acc_q_valid_o   = (level != '0);
    assign acc_q_addr_o    = head.addr;
    assign acc_q_data_op_o = head.instr;
    assign acc_q_arg_o     = head.args;
    assign acc_q_id_o      = head.rd;

    assign p_valid_o     = acc_p_valid_i;
    assign p_data_o      = acc_p_data_i;
    assign p_id_o        = acc_p_id_i;
    assign acc_p_ready_o = p_ready_i;
    assign outstanding_o = out_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_acc_adapter_sb.sv
// Self-checking bench for acc_adapter_sb: directed scenarios with literal
// expectations plus randomized traffic compared against a queue-based model.
module tb_acc_adapter_sb;

    localparam int DW = 32;
    localparam int NP = 8;
    localparam int FD = 2;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          q_valid;
    logic          q_ready;
    logic [31:0]   instr;
    logic [95:0]   q_rs;
    logic [2:0]    rs_valid;
    logic          k_accept, k_wb;
    logic [31:0]   prd_instr;
    logic [7:0]    pa;
    logic [23:0]   use_rs;
    logic [7:0]    pwb;
    logic [23:0]   op_imm;
    logic [71:0]   imm_sel;
    logic          acc_q_valid, acc_q_ready;
    logic [2:0]    acc_q_addr;
    logic [31:0]   acc_q_data_op;
    logic [95:0]   acc_q_arg;
    logic [4:0]    acc_q_id;
    logic          acc_p_valid, acc_p_ready;
    logic [31:0]   acc_p_data;
    logic [4:0]    acc_p_id;
    logic          p_valid, p_ready;
    logic [31:0]   p_data;
    logic [4:0]    p_id;
    logic [2:0]    outstanding;
    logic          err;

    acc_adapter_sb #(
        .DataWidth(DW), .NumPrd(NP), .FifoDepth(FD), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .q_valid_i(q_valid), .q_ready_o(q_ready), .q_instr_data_i(instr),
        .q_rs_i(q_rs), .q_rs_valid_i(rs_valid),
        .k_accept_o(k_accept), .k_writeback_o(k_wb),
        .prd_instr_data_o(prd_instr), .prd_accept_i(pa), .prd_use_rs_i(use_rs),
        .prd_writeback_i(pwb), .prd_op_imm_i(op_imm), .prd_imm_sel_i(imm_sel),
        .acc_q_valid_o(acc_q_valid), .acc_q_ready_i(acc_q_ready),
        .acc_q_addr_o(acc_q_addr), .acc_q_data_op_o(acc_q_data_op),
        .acc_q_arg_o(acc_q_arg), .acc_q_id_o(acc_q_id),
        .acc_p_valid_i(acc_p_valid), .acc_p_ready_o(acc_p_ready),
        .acc_p_data_i(acc_p_data), .acc_p_id_i(acc_p_id),
        .p_valid_o(p_valid), .p_ready_i(p_ready), .p_data_o(p_data), .p_id_o(p_id),
        .outstanding_o(outstanding), .err_o(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit [2:0]  addr;
        bit [31:0] op;
        bit [95:0] arg;
        bit [4:0]  id;
    } ent_t;

    ent_t      mq[$];
    int        m_out;
    bit [31:0] m_sb;
    bit        m_err;

    int        e_win;
    bit        e_acc, e_wb, e_stall, e_qready, e_push, e_hs, e_tracked;
    bit [4:0]  e_rd;
    bit [95:0] e_args;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Immediate value by arithmetic on the instruction fields
    function automatic bit [31:0] ref_imm(input bit [31:0] ins, input int sel);
        int v;
        case (sel)
            1: begin
                v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
                if (ins[31]) v -= 4096;
            end
            2: begin
                v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                if (ins[31]) v -= 4096;
            end
            3: v = int'(ins[31:12]) << 12;
            4: begin
                v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
                if (ins[31]) v -= (1 << 20);
            end
            default: begin
                v = int'(ins[31:20]);
                if (ins[31]) v -= 4096;
            end
        endcase
        return 32'(v);
    endfunction

    // Expected combinational decision for the current inputs and model state
    task automatic model_comb();
        bit miss;
        e_win = -1;
        for (int i = 0; i < NP; i++) if (pa[i] && e_win < 0) e_win = i;
        e_acc     = (e_win >= 0);
        e_rd      = instr[11:7];
        e_hs      = acc_p_valid && p_ready;
        e_wb      = 1'b0;
        e_tracked = 1'b0;
        e_stall   = 1'b0;
        e_args    = '0;
        miss      = 1'b0;
        if (e_acc) begin
            e_wb      = pwb[e_win];
            e_tracked = e_wb && (e_rd != 0);
            for (int j = 0; j < 3; j++) begin
                e_args[32*j +: 32] = op_imm[3*e_win + j]
                    ? ref_imm(instr, int'(imm_sel[9*e_win + 3*j +: 3]))
                    : q_rs[32*j +: 32];
                if (use_rs[3*e_win + j] && !rs_valid[j]) miss = 1'b1;
            end
            e_stall = miss || (mq.size() == FD) || (e_wb && m_out == MO) ||
                      (e_tracked && m_sb[e_rd] && !(e_hs && acc_p_id == e_rd));
        end
        e_qready = !e_acc || !e_stall;
        e_push   = q_valid && e_acc && !e_stall;
    endtask

    task automatic compare();
        chk("prd_instr", 128'(prd_instr), 128'(instr));
        chk("k_accept", 128'(k_accept), 128'(e_acc));
        chk("k_writeback", 128'(k_wb), 128'(e_wb));
        chk("q_ready", 128'(q_ready), 128'(e_qready));
        chk("p_valid", 128'(p_valid), 128'(acc_p_valid));
        chk("p_data", 128'(p_data), 128'(acc_p_data));
        chk("p_id", 128'(p_id), 128'(acc_p_id));
        chk("acc_p_ready", 128'(acc_p_ready), 128'(p_ready));
        chk("acc_q_valid", 128'(acc_q_valid), 128'(mq.size() > 0));
        chk("outstanding", 128'(outstanding), 128'(m_out));
        chk("err", 128'(err), 128'(m_err));
        if (mq.size() > 0) begin
            chk("acc_q_addr", 128'(acc_q_addr), 128'(mq[0].addr));
            chk("acc_q_data_op", 128'(acc_q_data_op), 128'(mq[0].op));
            chk("acc_q_arg", 128'(acc_q_arg), 128'(mq[0].arg));
            chk("acc_q_id", 128'(acc_q_id), 128'(mq[0].id));
        end
    endtask

    // Advance model state with the inputs seen at the clock edge
    task automatic model_update();
        bit dec;
        if (rst) begin
            mq.delete();
            m_out = 0;
            m_sb  = '0;
            m_err = 1'b0;
        end else begin
            if (e_hs && (m_out == 0 || (acc_p_id != 0 && !m_sb[acc_p_id]))) m_err = 1'b1;
            if (mq.size() > 0 && acc_q_ready) void'(mq.pop_front());
            if (e_push) mq.push_back('{addr: 3'(e_win), op: instr, arg: e_args, id: e_rd});
            dec   = e_hs && (m_out > 0);
            m_out = m_out + ((e_push && e_wb) ? 1 : 0) - (dec ? 1 : 0);
            if (e_hs && acc_p_id != 0) m_sb[acc_p_id] = 1'b0;
            if (e_push && e_tracked)   m_sb[e_rd]     = 1'b1;
        end
    endtask

    task automatic settle();
        #1;
        model_comb();
        compare();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        q_valid = 0; instr = '0; q_rs = '0; rs_valid = '0; pa = '0; use_rs = '0;
        pwb = '0; op_imm = '0; imm_sel = '0; acc_q_ready = 0; acc_p_valid = 0;
        acc_p_data = '0; acc_p_id = '0; p_ready = 1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        settle(); tick();
        settle(); tick();
        rst = 0;
    endtask

    task automatic req(input bit [7:0] a, input bit [4:0] rdv, input bit wbv);
        q_valid  = 1;
        pa       = a;
        pwb      = wbv ? '1 : '0;
        use_rs   = '1;
        rs_valid = 3'b111;
        op_imm   = '0;
        instr    = {20'h0, rdv, 7'h33};
        q_rs     = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    endtask

    initial begin
        logic [95:0] t96;
        logic [31:0] t32;
        int          ids[$];

        rst = 1;
        idle();
        m_out = 0; m_sb = '0; m_err = 1'b0;
        @(negedge clk);
        do_reset();

        settle();
        chk("reset_acc_q_valid", 128'(acc_q_valid), 128'(0));
        chk("reset_outstanding", 128'(outstanding), 128'(0));
        chk("reset_err", 128'(err), 128'(0));

        // Winner index 2 with writeback to rd 5
        req(8'b0010_0100, 5'd5, 1'b1);
        settle();
        chk("win_q_ready", 128'(q_ready), 128'(1));
        chk("win_k_wb", 128'(k_wb), 128'(1));
        tick();
        acc_q_ready = 1;
        settle();
        chk("win_addr", 128'(acc_q_addr), 128'(2));
        chk("win_id", 128'(acc_q_id), 128'(5));
        chk("win_outstanding", 128'(outstanding), 128'(1));
        chk("raw_stall", 128'(q_ready), 128'(0));
        tick();
        acc_p_valid = 1; acc_p_id = 5'd5;
        settle();
        chk("raw_accept_on_clear", 128'(q_ready), 128'(1));
        tick();
        acc_p_valid = 0;
        settle();
        chk("raw_still_pending", 128'(q_ready), 128'(0));
        chk("raw_outstanding", 128'(outstanding), 128'(1));
        tick();
        q_valid = 0; pa = '0; acc_p_valid = 1; acc_p_id = 5'd5;
        settle(); tick();
        acc_p_valid = 0;
        settle();
        chk("raw_drain_outstanding", 128'(outstanding), 128'(0));
        chk("raw_drain_err", 128'(err), 128'(0));
        tick();

        // Outstanding limit with the queue draining every cycle
        do_reset();
        acc_q_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            req(8'h01, 5'(k), 1'b1);
            acc_q_ready = 1;
            settle();
            chk("lim_accept", 128'(q_ready), 128'(1));
            tick();
        end
        req(8'h01, 5'd5, 1'b1);
        acc_q_ready = 1;
        settle();
        chk("lim_fifth_stall", 128'(q_ready), 128'(0));
        chk("lim_outstanding", 128'(outstanding), 128'(4));
        tick();
        acc_p_valid = 1; acc_p_id = 5'd1;
        settle(); tick();
        acc_p_valid = 0;
        settle();
        chk("lim_resume", 128'(q_ready), 128'(1));
        chk("lim_after_resp", 128'(outstanding), 128'(3));
        tick();
        q_valid = 0; pa = '0;
        settle();
        chk("lim_refill", 128'(outstanding), 128'(4));
        tick();

        // Request FIFO capacity
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req(8'h80, 5'(k + 1), 1'b0);
            settle();
            chk("fifo_accept", 128'(q_ready), 128'(k < 2));
            tick();
        end
        acc_q_ready = 1;
        settle();
        chk("fifo_full_with_pop", 128'(q_ready), 128'(0));
        tick();
        settle();
        chk("fifo_resume", 128'(q_ready), 128'(1));
        chk("fifo_head_addr", 128'(acc_q_addr), 128'(7));
        chk("fifo_head_id", 128'(acc_q_id), 128'(2));
        tick();

        // Missing source operand, then no predecoder claim
        do_reset();
        req(8'h10, 5'd3, 1'b0);
        use_rs = '0; use_rs[14:12] = 3'b011; rs_valid = 3'b001;
        settle();
        chk("src_stall", 128'(q_ready), 128'(0));
        chk("src_k_accept", 128'(k_accept), 128'(1));
        tick();
        settle();
        chk("src_nothing_queued", 128'(acc_q_valid), 128'(0));
        pa = '0;
        settle();
        chk("none_q_ready", 128'(q_ready), 128'(1));
        chk("none_k_accept", 128'(k_accept), 128'(0));
        tick();
        settle();
        chk("none_nothing_queued", 128'(acc_q_valid), 128'(0));

        // Immediate operands: I and U formats
        do_reset();
        req(8'h02, 5'd0, 1'b0);
        instr = 32'h1234_5037;
        op_imm[5:3] = 3'b011; imm_sel[17:9] = {3'd0, 3'd3, 3'd0};
        q_rs = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        settle(); tick();
        instr = 32'hFFF0_0093; imm_sel[17:9] = '0;
        acc_q_ready = 1;
        settle();
        chk("imm_i_pos", 128'(acc_q_arg[31:0]), 128'(32'h0000_0123));
        chk("imm_u", 128'(acc_q_arg[63:32]), 128'(32'h1234_5000));
        chk("imm_rs3", 128'(acc_q_arg[95:64]), 128'(32'hCCCC_CCCC));
        tick();
        settle();
        chk("imm_i_neg", 128'(acc_q_arg[31:0]), 128'(32'hFFFF_FFFF));
        tick();

        // Spurious response, then reset with queued entries
        do_reset();
        acc_p_valid = 1; acc_p_id = 5'd0;
        settle(); tick();
        acc_p_valid = 0;
        settle();
        chk("err_set", 128'(err), 128'(1));
        chk("err_count_floor", 128'(outstanding), 128'(0));
        tick();
        req(8'h01, 5'd0, 1'b0);
        settle(); tick();
        settle(); tick();
        settle();
        chk("err_sticky", 128'(err), 128'(1));
        chk("pre_rst_queued", 128'(acc_q_valid), 128'(1));
        rst = 1;
        settle(); tick();
        rst = 0;
        idle();
        settle();
        chk("rst_flush", 128'(acc_q_valid), 128'(0));
        chk("rst_err_clear", 128'(err), 128'(0));
        tick();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 149) == 0);
            q_valid  = ($urandom_range(0, 3) != 0);
            instr    = $urandom;
            q_rs     = {$urandom, $urandom, $urandom};
            rs_valid = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            t32      = $urandom;
            pa       = ($urandom_range(0, 5) == 0) ? 8'h00 : (t32[7:0] & t32[15:8]);
            use_rs   = 24'($urandom);
            pwb      = 8'($urandom);
            op_imm   = 24'($urandom);
            t96      = {$urandom, $urandom, $urandom};
            imm_sel  = t96[71:0];
            acc_q_ready = ($urandom_range(0, 2) != 0);
            p_ready     = ($urandom_range(0, 3) != 0);
            acc_p_data  = $urandom;
            acc_p_valid = 0;
            acc_p_id    = '0;
            if (m_out > 0 && $urandom_range(0, 2) == 0) begin
                ids.delete();
                for (int b = 1; b < 32; b++) if (m_sb[b]) ids.push_back(b);
                acc_p_valid = 1;
                acc_p_id    = (ids.size() > 0) ? 5'(ids[$urandom_range(0, ids.size() - 1)]) : 5'd0;
            end
            settle();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_adapter_sb.md
ACC_ADAPTER_SB -- requirements
Module: acc_adapter_sb

Interface
REQ-001 SHALL have parameter DataWidth, default 32, operand and result width.
REQ-002 SHALL have parameter NumPrd, default 8, number of predecoders (>=1).
REQ-003 SHALL have parameter FifoDepth, default 2, request FIFO entries (>=1).
REQ-004 SHALL have parameter MaxOutstanding, default 4, max in-flight writeback offloads (>=1).
REQ-005 SHALL define localparam AddrWidth = max(1, $clog2(NumPrd)).
REQ-006 SHALL have clk_i, input, 1, sole clock; rising edge.
REQ-007 SHALL have rst_i, input, 1, reset; synchronous and active-high.
REQ-008 SHALL have q_valid_i / q_ready_o, in / out, 1 each, offload request handshake.
REQ-009 SHALL have q_instr_data_i in 32, instruction; q_rs_i in 3*DataWidth, rs1..rs3 (rs1 at LSBs); q_rs_valid_i in 3, per-source valid.
REQ-010 SHALL have k_accept_o out 1 and k_writeback_o out 1, combinational same-cycle offload decision.
REQ-011 SHALL have prd_instr_data_o out 32, prd_accept_i in NumPrd, prd_use_rs_i in 3*NumPrd, prd_writeback_i in NumPrd, prd_op_imm_i in 3*NumPrd (1 = immediate operand), prd_imm_sel_i in 9*NumPrd (3 bits per operand: 0 I, 1 S, 2 B, 3 U, 4 J, else I).
REQ-012 SHALL have acc_q_valid_o out 1, acc_q_ready_i in 1, acc_q_addr_o out AddrWidth, acc_q_data_op_o out 32, acc_q_arg_o out 3*DataWidth, acc_q_id_o out 5.
REQ-013 SHALL have acc_p_valid_i in 1, acc_p_ready_o out 1, acc_p_data_i in DataWidth, acc_p_id_i in 5: accelerator response.
REQ-014 SHALL have p_valid_o out 1, p_ready_i in 1, p_data_o out DataWidth, p_id_o out 5: response to core.
REQ-015 SHALL have outstanding_o out $clog2(MaxOutstanding+1), in-flight count; err_o out 1, sticky protocol error.

Function
REQ-016 SHALL drive prd_instr_data_o = q_instr_data_i combinationally.
REQ-017 SHALL select the lowest-index asserted prd_accept_i bit as winner; k_accept_o = |prd_accept_i; acc_q_addr_o of the enqueued entry = winner index in binary.
REQ-018 SHALL form per-operand value: prd_op_imm_i=0 -> rs field; =1 -> RISC-V sign-extended immediate of the selected type, zero-/sign-extended to DataWidth.
REQ-019 SHALL treat rd = q_instr_data_i[11:7]; k_writeback_o = winner prd_writeback_i; tracked = k_writeback_o && rd != 0.
REQ-020 SHALL keep a 32-bit pending-rd scoreboard and an outstanding counter.
REQ-021 SHALL assert stall when k_accept_o and any of: a used source has q_rs_valid_i=0; FIFO full; k_writeback_o && outstanding_o == MaxOutstanding; tracked && scoreboard[rd] set.
REQ-022 SHALL drive q_ready_o = ~k_accept_o | ~stall; a non-accepted request completes with nothing enqueued.
REQ-023 SHALL enqueue {addr, instr, args, rd} on q_valid_i && k_accept_o && ~stall; entry visible on acc_q_* next cycle (1-cycle latency, no fall-through).
REQ-024 SHALL present FIFO head on acc_q_* with acc_q_valid_o = ~empty; pop on acc_q_valid_o && acc_q_ready_i; simultaneous push/pop on full FIFO SHALL NOT be accepted (full stalls regardless of pop).
REQ-025 SHALL increment outstanding on enqueue with k_writeback_o; set scoreboard[rd] on enqueue when tracked.
REQ-026 SHALL pass responses through combinationally: p_valid_o = acc_p_valid_i, p_data_o/p_id_o = acc_p_*, acc_p_ready_o = p_ready_i.
REQ-027 SHALL on response handshake decrement outstanding and clear scoreboard[acc_p_id_i] (id 0 clears nothing).
REQ-028 SHALL on simultaneous increment and decrement leave outstanding unchanged; simultaneous set and clear of same rd SHALL result set.
REQ-029 SHALL set err_o on response handshake when outstanding_o == 0, or acc_p_id_i != 0 with scoreboard bit clear; counter SHALL saturate at 0.

Reset
REQ-030 SHALL on rst_i high at a clock edge empty the FIFO, clear scoreboard, outstanding_o = 0, err_o = 0; acc_q_valid_o = 0 from the following cycle, including mid-transaction.
REQ-031 SHALL hold q_ready_o/k_accept_o purely combinational and unaffected by reset except via FIFO-full and counter state.

Verification
REQ-032 SHALL cover: prd_accept_i=8'b0010_0100, writeback=1, rd=5, sources valid -> q_ready_o=1, next cycle acc_q_addr_o=2, acc_q_id_o=5, outstanding_o=1.
REQ-033 SHALL cover: rd=5 pending, new offload writing rd=5 -> q_ready_o=0 until response id 5 handshakes, then accepted same cycle as clear+set, scoreboard[5] stays 1.
REQ-034 SHALL cover: MaxOutstanding=4, five back-to-back writeback offloads rd=1..5, acc_q_ready_i=1 -> fifth stalls until one response; FifoDepth=2 with acc_q_ready_i=0 -> third stalls.
REQ-035 SHALL cover: use_rs=3'b011, q_rs_valid_i=3'b001 -> q_ready_o=0, nothing enqueued; prd_accept_i=0 -> q_ready_o=1, k_accept_o=0.
REQ-036 SHALL cover: response with outstanding_o=0 -> err_o=1 sticky until rst_i; rst_i with 2 entries queued -> acc_q_valid_o=0 next cycle.
